reg_writeback: RTL
==================

# reg_writeback

Write-back arbiter that drives the register file's write port (regWrite/writeReg/writeData). It merges the single-cycle ALU/pipeline result stream with results from long-latency producers (multiply/divide, loads) over a valid/ready handshake. Long-latency results are held in a small FIFO until the write port is free. The block sits between the execute/memory stages and the register file, and exports a pending-write query for the hazard unit.

## Interface

Parameters:
- DEPTH, 2, FIFO entries for long-latency results (≥1)
- DATA_WIDTH, 32, result width
- ADDR_WIDTH, 5, register index width

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  clock; all state updates on the rising edge
  - rst_n  in  1  synchronous active-low reset
- ALU/pipeline result (always accepted):
  - aluValid  in  1  pipeline result valid this cycle
  - aluReg  in  ADDR_WIDTH  destination register
  - aluData  in  DATA_WIDTH  result value
- Long-latency result (handshake):
  - mdValid  in  1  long-latency result offered
  - mdReg  in  ADDR_WIDTH  destination register
  - mdData  in  DATA_WIDTH  result value
  - mdReady  out  1  FIFO can accept; a transfer occurs when mdValid && mdReady
- Register file write port:
  - regWrite  out  1  write enable to register file
  - writeReg  out  ADDR_WIDTH  write index
  - writeData  out  DATA_WIDTH  write value
- Hazard query:
  - queryReg  in  ADDR_WIDTH  register to check
  - queryHit  out  1  a write to queryReg is pending (combinational)

## Operation

Reset:
- rst_n low at an edge clears the FIFO (count=0, all kill flags cleared) and sets regWrite=0, writeReg=0, writeData=0.
- mdReady is forced to 0 while rst_n is low.

Output stage: regWrite/writeReg/writeData are registered. Each edge they load, in priority order:
1. ALU: aluValid && aluReg!=0 loads {1, aluReg, aluData}.
2. FIFO head: otherwise, if the FIFO is non-empty, pop the head.
   - If the head's kill flag is clear, load {1, head.reg, head.data}.
   - If the head is killed, load regWrite=0. writeReg and writeData then hold their previous values.
3. Idle: otherwise regWrite=0, and writeReg/writeData hold.

Handshake and FIFO:
- mdReady = rst_n && (count < DEPTH), evaluated on the pre-edge count.
  - A full FIFO therefore deasserts mdReady even when a pop occurs in the same cycle.
- An accepted transfer with mdReg==0 is discarded and not enqueued.
- An accepted transfer with mdReg!=0 is enqueued at the tail with its kill flag clear.
- FIFO order is strict: pops occur in acceptance order. Pointers wrap modulo DEPTH.

Kill (WAW resolution):
- When aluValid && aluReg!=0, every valid FIFO entry with reg==aluReg gets its kill flag set at that edge.
- The ALU result is program-order younger; the issue logic guarantees this.
- An entry enqueued in the same cycle with mdReg==aluReg is also killed.

Register 0:
- Writes to register 0 never reach the port: regWrite is never asserted with writeReg==0.
- With aluValid && aluReg==0, the ALU input is treated as absent, so the FIFO may pop that cycle.

queryHit:
- 1 if queryReg!=0 and either of these holds:
  - regWrite && writeReg==queryReg, or
  - any valid, non-killed FIFO entry has reg==queryReg.
- Otherwise 0.

## Timing

- ALU latency: an ALU result presented in cycle N is on the write port in cycle N+1. The register file commits it at the end of N+1.
- Long-latency minimum latency: accepted in cycle N, enqueued at the end of N, on the write port in cycle N+2 if there is no ALU write in N+1.
- Long-latency worst case: a FIFO entry waits for every cycle that carries a valid non-zero ALU write. Continuous ALU traffic starves the FIFO, and this is by design; the upstream pipeline guarantees gaps.
- Throughput: one register-file write per cycle.
- Reset mid-operation: queued entries are lost, and no write is issued in the cycle after reset.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with aluValid=1, aluReg=10, mdValid=1.
  - Required: regWrite=0, writeReg=0, writeData=0, mdReady=0, queryHit=0.
- ALU path: aluReg=10, aluData=32'hFFFFFFFF in cycle N.
  - Required: cycle N+1 has regWrite=1, writeReg=10, writeData=32'hFFFFFFFF.
  - Required: the register file then reads readData1=-1 for reg 10.
- Long-latency path: mdReg=20, mdData=32'hFFFFFFFE accepted in cycle N, no ALU traffic.
  - Required: regWrite=1, writeReg=20 in cycle N+2.
  - Required: queryHit=1 for queryReg=20 from cycle N+1 through N+2.
- Back-pressure and order: ALU writes in 4 consecutive cycles while md offers reg 1, 2, 3 (values 1, 2, 3).
  - Required: mdReady drops after 2 accepts.
  - Required: after the ALU stops, writes occur to regs 1, 2, 3 in that order in consecutive cycles.
- Register 0: aluReg=0 with a queued entry for reg 5 in the same cycle.
  - Required: the FIFO pops, and regWrite=1, writeReg=5 next cycle.
  - Required: an md transfer with mdReg=0 leaves count unchanged.
- Kill: reg 30 is queued with value -3 while the ALU writes reg 30 with value 7.
  - Required: queryHit for 30 drops once the ALU write leaves the port.
  - Required: the killed pop produces regWrite=0, and the register file keeps 7.

Source files
------------

// File: rtl/reg_writeback.sv
// reg_writeback: write-back arbiter for the register file write port.
//
// Merges the single-cycle ALU/pipeline result stream with results from
// long-latency producers (multiply/divide, loads). Long-latency results
// are buffered in a small FIFO and written only when the ALU does not own
// the write port. ALU writes always win the port.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   aluValid, aluReg, aluData       pipeline result (always accepted)
//   mdValid, mdReg, mdData, mdReady long-latency result handshake
//   regWrite, writeReg, writeData   registered register-file write port
//   queryReg, queryHit              combinational pending-write query
//
// Handshake: a long-latency transfer happens on a rising edge where
// mdValid && mdReady. mdReady depends only on the FIFO occupancy before
// the edge and rst_n, never on mdValid. The producer must hold
// mdReg/mdData stable while mdValid is high and mdReady is low. An
// accepted transfer to register 0 is dropped instead of being queued.
//
// WAW handling: a queued entry whose destination is overwritten by a
// (younger) ALU write is marked killed. It still drains in order, but its
// pop leaves regWrite low so the older value cannot clobber the newer one.

module reg_writeback #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluReg,
    input  logic [DATA_WIDTH-1:0] aluData,
    input  logic                  mdValid,
    input  logic [ADDR_WIDTH-1:0] mdReg,
    input  logic [DATA_WIDTH-1:0] mdData,
    output logic                  mdReady,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] writeReg,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] queryReg,
    output logic                  queryHit
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(DEPTH - 1);

    // FIFO storage. ent_used marks occupied slots so the kill and query
    // logic can scan slots without decoding the head/count window.
    logic [ADDR_WIDTH-1:0] ent_reg  [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]      ent_used;
    logic [DEPTH-1:0]      ent_kill;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic             alu_write;
    logic             pop;
    logic             enqueue;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;

    // An ALU result to register 0 is treated as no ALU result at all, so
    // it neither takes the port nor kills queued entries.
    assign alu_write = aluValid && (aluReg != '0);
    assign pop       = !alu_write && (count != '0);
    assign mdReady   = rst_n && (count < FULL_COUNT);
    assign enqueue   = mdValid && mdReady && (mdReg != '0);

    assign head_next = (head == LAST_SLOT) ? '0 : head + PTR_W'(1);
    assign tail_next = (tail == LAST_SLOT) ? '0 : tail + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            ent_used  <= '0;
            ent_kill  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i]  <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            // Output stage: ALU first, then FIFO head, else idle.
            // writeReg/writeData hold whenever regWrite is low.
            if (alu_write) begin
                regWrite  <= 1'b1;
                writeReg  <= aluReg;
                writeData <= aluData;
            end else if (pop && !ent_kill[head]) begin
                regWrite  <= 1'b1;
                writeReg  <= ent_reg[head];
                writeData <= ent_data[head];
            end else begin
                regWrite  <= 1'b0;
            end

            // Kill older queued writes to the register the ALU overwrites.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_write && ent_used[i] && (ent_reg[i] == aluReg)) begin
                    ent_kill[i] <= 1'b1;
                end
            end

            // Pop never coincides with an ALU write, so it cannot race the
            // kill loop above on the head slot.
            if (pop) begin
                ent_used[head] <= 1'b0;
                ent_kill[head] <= 1'b0;
                head           <= head_next;
            end

            // The tail slot is free whenever enqueue is possible, so the
            // kill loop never touches it in the same edge.
            if (enqueue) begin
                ent_used[tail] <= 1'b1;
                ent_kill[tail] <= alu_write && (mdReg == aluReg);
                ent_reg[tail]  <= mdReg;
                ent_data[tail] <= mdData;
                tail           <= tail_next;
            end

            case ({enqueue, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Pending-write query: the write currently on the port or any live
    // queued entry. Register 0 is never reported as pending.
    always_comb begin
        logic hit;
        hit = 1'b0;
        if (regWrite && (writeReg == queryReg)) begin
            hit = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_used[i] && !ent_kill[i] && (ent_reg[i] == queryReg)) begin
                hit = 1'b1;
            end
        end
        queryHit = hit && (queryReg != '0);
    end

endmodule
